sd_int_ctrl: RTL and testbench

- Parametrised successor to the fixed normal/error interrupt status registers of the SD host.
- Captures event requests from the CMD/DAT engines into sticky status bits and runs the enable/ack handshake with each requester.
- Gives the CPU status-enable, signal-enable and write-1-to-clear access, and generates one moderated interrupt line.
- Width, error-summary position and interrupt coalescing are configurable.

---
 rtl/sd_int_ctrl.sv | 144 ++++++++++++++
 tb/tb_sd_int_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_int_ctrl.sv
// rtl/sd_int_ctrl.sv - SD host interrupt status/enable registers with a coalesced interrupt line
// Sticky event capture with per-source acks, W1C/enable access and an IDLE/WAIT/ASSERT moderation FSM.
module sd_int_ctrl #(
  parameter int              N_EV        = 16,
  parameter logic [N_EV-1:0] ERR_MASK    = 16'h7E00,
  parameter int              SUMMARY_BIT = 15,
  parameter int              COAL_W      = 8,
  parameter int              COAL_TMO    = 200
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_EV-1:0] ev_req,
  output logic [N_EV-1:0] ev_ack,
  input  logic            wr_en,
  input  logic [1:0]      wr_sel,
  input  logic [N_EV-1:0] wr_data,
  output logic [N_EV-1:0] status_out,
  output logic [N_EV-1:0] stat_en_out,
  output logic [N_EV-1:0] sig_en_out,
  output logic            irq
);

  localparam logic [N_EV-1:0]   ONE_BIT   = 1;
  localparam logic [N_EV-1:0]   SUM_MASK  = ONE_BIT << SUMMARY_BIT;
  localparam logic [COAL_W-1:0] CNT_MAX   = '1;
  localparam logic [COAL_W-1:0] CNT_ONE   = 1;
  // The timer starts one cycle after the status bit becomes visible, hence the -2.
  localparam logic [COAL_W-1:0] TMO_LAST  = COAL_W'((COAL_TMO >= 2) ? COAL_TMO - 2 : 0);
  localparam bit                TMO_SHORT = (COAL_TMO < 2);

  typedef enum logic [1:0] {IDLE, WAIT, ASSERT} state_t;

  state_t            state, state_n;
  logic [N_EV-1:0]   status, status_n, stat_en, sig_en, req_q;
  logic [N_EV-1:0]   rise, set_bits, w1c, en_clr;
  logic [COAL_W-1:0] thresh, ev_cnt, ev_cnt_n, cnt_inc, timer, timer_n;
  logic              hit, pend, irq_n;

  always_comb begin
    rise     = ev_req & ~req_q;
    w1c      = (wr_en && wr_sel == 2'd0) ? wr_data : '0;
    en_clr   = (wr_en && wr_sel == 2'd1) ? ~wr_data : '0;
    set_bits = rise & stat_en & ~SUM_MASK;
    // Set beats W1C; disabling a bit beats a same-cycle set.
    status_n = ((status & ~w1c) | set_bits) & ~en_clr & ~SUM_MASK;
    hit      = |(set_bits & ~en_clr & sig_en);
  end

  always_comb begin
    status_out              = status;
    status_out[SUMMARY_BIT] = |(status & ERR_MASK & ~SUM_MASK);
  end

  assign stat_en_out = stat_en;
  assign sig_en_out  = sig_en;
  assign pend        = |(status_out & sig_en);
  assign cnt_inc     = (hit && ev_cnt != CNT_MAX) ? ev_cnt + 1'b1 : ev_cnt;

  always_comb begin
    state_n  = state;
    ev_cnt_n = ev_cnt;
    timer_n  = timer;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (pend) begin
          if (thresh == '0 || TMO_SHORT) begin
            state_n  = ASSERT;
            ev_cnt_n = '0;
          end else begin
            state_n  = WAIT;
            ev_cnt_n = cnt_inc;
          end
        end else begin
          // Remember the capture cycle so it counts once pend rises next cycle.
          ev_cnt_n = hit ? CNT_ONE : '0;
        end
      end
      WAIT: begin
        if (!pend) begin
          state_n  = IDLE;
          ev_cnt_n = '0;
          timer_n  = '0;
        end else if (ev_cnt >= thresh || timer == TMO_LAST) begin
          state_n  = ASSERT;
          ev_cnt_n = '0;
          timer_n  = '0;
        end else begin
          timer_n  = timer + 1'b1;
          ev_cnt_n = cnt_inc;
        end
      end
      ASSERT: begin
        ev_cnt_n = '0;
        timer_n  = '0;
        if (!pend) state_n = IDLE;
      end
      default: begin
        state_n  = IDLE;
        ev_cnt_n = '0;
        timer_n  = '0;
      end
    endcase
    irq_n = (state_n == ASSERT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ev_cnt <= '0;
      timer  <= '0;
      irq    <= 1'b0;
    end else begin
      state  <= state_n;
      ev_cnt <= ev_cnt_n;
      timer  <= timer_n;
      irq    <= irq_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status  <= '0;
      stat_en <= '1;
      sig_en  <= '0;
      thresh  <= '0;
      req_q   <= '0;
      ev_ack  <= '0;
    end else begin
      req_q  <= ev_req;
      ev_ack <= rise;
      status <= status_n;
      if (wr_en) begin
        case (wr_sel)
          2'd1:    stat_en <= wr_data;
          2'd2:    sig_en  <= wr_data;
          2'd3:    thresh  <= wr_data[COAL_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_int_ctrl.sv
// tb/tb_sd_int_ctrl.sv - scoreboard bench for sd_int_ctrl against a behavioural model
module tb_sd_int_ctrl;

  localparam int          SB   = 15;
  localparam logic [15:0] ERRM = 16'h7E00;
  localparam int          TMO  = 200;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] ev_req, ev_ack, wr_data, status_out, stat_en_out, sig_en_out;
  logic        wr_en, irq;
  logic [1:0]  wr_sel;

  always #5 clock = ~clock;

  sd_int_ctrl #(
    .N_EV(16), .ERR_MASK(ERRM), .SUMMARY_BIT(SB), .COAL_W(8), .COAL_TMO(TMO)
  ) dut (
    .clock(clock), .reset(reset), .ev_req(ev_req), .ev_ack(ev_ack),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .status_out(status_out), .stat_en_out(stat_en_out), .sig_en_out(sig_en_out),
    .irq(irq)
  );

  typedef struct packed {
    logic [15:0] status;
    logic [15:0] stat_en;
    logic [15:0] sig_en;
    logic [15:0] ack;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register image plus an interrupt "episode" tracker.
  logic [15:0] m_status, m_stat_en, m_sig_en, m_reqq, m_ack;
  logic        m_irq;
  int          m_thresh, m_phase, m_events, m_seen, cyc;

  function automatic logic [15:0] m_sout();
    logic [15:0] s;
    s     = m_status;
    s[SB] = |(m_status & ERRM);
    return s;
  endfunction

  task automatic model_reset();
    m_status = '0; m_stat_en = '1; m_sig_en = '0; m_reqq = '0; m_ack = '0;
    m_irq = 1'b0; m_thresh = 0; m_phase = 0; m_events = 0; m_seen = 0;
  endtask

  task automatic step(input logic [15:0] req, input logic we, input logic [1:0] sel,
                      input logic [15:0] data);
    logic [15:0] rise, clr, dis, setb, nstat;
    logic        pend, hit, nirq;
    exp_t        e;
    ev_req = req; wr_en = we; wr_sel = sel; wr_data = data;
    pend  = |(m_sout() & m_sig_en);
    rise  = req & ~m_reqq;
    clr   = (we && sel == 2'd0) ? data : 16'h0;
    dis   = (we && sel == 2'd1) ? ~data : 16'h0;
    setb  = rise & m_stat_en;
    setb[SB] = 1'b0;
    nstat = ((m_status & ~clr) | setb) & ~dis;
    nstat[SB] = 1'b0;
    hit   = |(setb & ~dis & m_sig_en);
    nirq  = 1'b0;
    // phase 0: quiet, 1: moderating, 2: interrupting
    if (!pend) begin
      m_events = (m_phase == 0) ? int'(hit) : 0;
      m_phase  = 0;
    end else if (m_phase == 2) begin
      nirq = 1'b1;
    end else if (m_phase == 0) begin
      m_seen = cyc;
      if (m_thresh == 0) begin
        m_phase = 2; nirq = 1'b1; m_events = 0;
      end else begin
        m_phase = 1; m_events = m_events + int'(hit);
      end
    end else begin
      if (m_events >= m_thresh || cyc - m_seen == TMO - 1) begin
        m_phase = 2; nirq = 1'b1; m_events = 0;
      end else begin
        m_events = m_events + int'(hit);
      end
    end
    if (m_events > 255) m_events = 255;
    if (we && sel == 2'd1) m_stat_en = data;
    if (we && sel == 2'd2) m_sig_en  = data;
    if (we && sel == 2'd3) m_thresh  = int'(data[7:0]);
    m_status = nstat; m_reqq = req; m_ack = rise; m_irq = nirq;
    e.status = m_sout(); e.stat_en = m_stat_en; e.sig_en = m_sig_en;
    e.ack = m_ack; e.irq = m_irq;
    sb_q.push_back(e);
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic [15:0] req);
    for (int i = 0; i < n; i++) step(req, 1'b0, 2'd0, 16'h0);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [15:0] data);
    step(ev_req, 1'b1, sel, data);
  endtask

  task automatic chk_reset_vals();
    chk("rst_status", status_out, 16'h0);
    chk("rst_stat_en", stat_en_out, 16'hFFFF);
    chk("rst_sig_en", sig_en_out, 16'h0);
    chk("rst_ack", ev_ack, 16'h0);
    chk("rst_irq", irq, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("status", status_out, e.status);
        chk("stat_en", stat_en_out, e.stat_en);
        chk("sig_en", sig_en_out, e.sig_en);
        chk("ack", ev_ack, e.ack);
        chk("irq", irq, e.irq);
      end
    end
  end

  initial begin : driver
    logic [15:0] req, d;
    logic [1:0]  s;
    cyc = 0;
    reset = 1'b0; ev_req = '0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    model_reset();
    repeat (2) @(negedge clock);
    chk_reset_vals();
    reset = 1'b1;

    // capture, one-cycle ack, no recapture while held
    idle(3, 16'h0001);
    idle(2, 16'h0000);
    // immediate irq with thresh 0, then W1C drops it
    wr(2'd2, 16'h0001);
    wr(2'd3, 16'h0000);
    wr(2'd0, 16'h0001);
    idle(1, 16'h0001);
    idle(3, 16'h0000);
    step(16'h0, 1'b1, 2'd0, 16'h0001);
    idle(3, 16'h0000);
    // error bit and summary; summary is not W1C-able
    idle(2, 16'h0200);
    step(16'h0, 1'b1, 2'd0, 16'h8000);
    step(16'h0, 1'b1, 2'd0, 16'h0200);
    idle(2, 16'h0000);
    // rise vs W1C, stat_en clear, masked capture still acked
    step(16'h0008, 1'b1, 2'd0, 16'h0008);
    idle(2, 16'h0000);
    step(16'h0000, 1'b1, 2'd1, 16'hFFF7);
    idle(1, 16'h0000);
    idle(2, 16'h0008);
    idle(1, 16'h0000);
    wr(2'd1, 16'hFFFF);
    // coalescing by count, thresh 3
    wr(2'd0, 16'hFFFF);
    wr(2'd2, 16'hFFFF);
    wr(2'd3, 16'h0003);
    idle(1, 16'h0010); idle(2, 16'h0000);
    idle(1, 16'h0020); idle(2, 16'h0000);
    idle(1, 16'h0040); idle(4, 16'h0000);
    wr(2'd0, 16'hFFFF);
    idle(3, 16'h0000);
    // coalescing by timeout
    idle(1, 16'h0080);
    idle(TMO + 5, 16'h0000);
    wr(2'd0, 16'hFFFF);
    idle(3, 16'h0000);

    // randomized traffic
    req = '0;
    for (int i = 0; i < 3000; i++) begin
      req = req ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        s = 2'($urandom_range(0, 3));
        case (s)
          2'd1:    d = ~(16'($urandom) & 16'($urandom) & 16'($urandom));
          2'd3:    d = 16'($urandom_range(0, 6));
          default: d = 16'($urandom);
        endcase
        step(req, 1'b1, s, d);
      end else begin
        step(req, 1'b0, 2'd0, 16'h0);
      end
    end

    // async reset while irq is high and req[2] is held
    step(16'h0, 1'b1, 2'd0, 16'hFFFF);
    wr(2'd1, 16'hFFFF);
    wr(2'd2, 16'hFFFF);
    wr(2'd3, 16'h0000);
    idle(4, 16'h0004);
    chk("irq_before_reset", irq, 1'b1);
    #3 reset = 1'b0;
    #1 chk_reset_vals();
    @(negedge clock);
    chk_reset_vals();
    reset = 1'b1;
    model_reset();
    idle(3, 16'h0004);
    idle(2, 16'h0000);

    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
